fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t : REQ (may issue a request) / WAIT (one request outstanding)
//   NOP_INSTR     : instruction presented on if_instr when IF/ID is empty
//   PC_STEP       : sequential fetch increment
//   align_pc()    : clears the two low address bits of a redirect target
package fetch_pkg;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetched instruction that
// arrived while decode was stalled with a live IF/ID entry.
//   clk, rst              : clock, synchronous active-high reset
//   load                  : capture load_pc/load_instr, mark valid
//   unload                : entry consumed by IF/ID, mark empty
//   clear                 : discard entry (redirect); wins over load/unload
//   buf_valid/pc/instr    : held entry
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        buf_valid,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_instr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
    end else if (unload) begin
      buf_valid <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while
  // buf_valid is set, and buf_valid is reset.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_pc    <= load_pc;
      buf_instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one request at a
// time on the instruction-memory handshake, and presents fetched instructions
// to decode through the IF/ID register. Taken branches from execute redirect
// the PC and squash wrong-path work, including an in-flight response.
// Decode stalls are absorbed by a one-entry skid buffer.
//
// Optional feature: define FETCH_REDIRECT_BYPASS_EN to let a redirect in the
// REQ state drive the target onto the memory port in the same cycle.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   br_taken, br_target  : redirect from execute (target low bits ignored)
//   stall                : decode cannot accept; IF/ID holds
//   imem_req, imem_addr  : request valid / address
//   imem_gnt             : request accepted this cycle
//   imem_rvalid/rdata    : in-order response, at most one per grant
//   if_valid/pc/instr    : IF/ID register (if_instr = NOP when empty)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

`ifdef FETCH_REDIRECT_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  fetch_state_t state, state_next;
  logic [31:0]  pc, req_pc;
  logic         kill;
  logic [31:0]  target;
  logic         grant, resp_fire, deliver, redirect_bypass;
  logic         buf_valid, buf_load, buf_unload;
  logic [31:0]  buf_pc, buf_instr;

  assign target          = align_pc(br_target);
  assign redirect_bypass = BYPASS_EN && br_taken && (state == REQ);
  assign grant           = imem_req && imem_gnt;
  assign resp_fire       = (state == WAIT) && imem_rvalid;
  // A response reaches decode only if it is on the current path and no
  // redirect arrives in the same cycle.
  assign deliver         = resp_fire && !kill && !br_taken;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: each combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      REQ:     if (grant)       state_next = WAIT;
      WAIT:    if (imem_rvalid) state_next = REQ;
      default:                  state_next = REQ;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Requests are withheld while the skid entry is occupied so at most one
  // more instruction can pile up behind a stalled decode.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (!rst && state == REQ) begin
      if (redirect_bypass) begin
        imem_req  = 1'b1;
        imem_addr = target;
      end else begin
        imem_req = !buf_valid;
      end
    end
  end

  // ---------------- PC, request PC, kill ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      kill   <= 1'b0;
    end else begin
      if (br_taken) begin
        if (redirect_bypass && grant) begin
          pc     <= target + PC_STEP;
          req_pc <= target;
        end else begin
          pc <= target;
        end
      end else if (grant) begin
        pc     <= pc + PC_STEP;
        req_pc <= pc;
      end

      // Kill marks the single outstanding response as wrong-path. A response
      // landing in the redirect cycle is dropped directly, so no kill then.
      if (br_taken) begin
        kill <= ((state == WAIT) && !imem_rvalid) || (grant && !redirect_bypass);
      end else if (resp_fire) begin
        kill <= 1'b0;
      end
    end
  end

  // ---------------- IF/ID register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= NOP_INSTR;
    end else if (br_taken) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (buf_valid) begin
        if_valid <= 1'b1;
        if_pc    <= buf_pc;
        if_instr <= buf_instr;
      end else if (deliver) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_instr <= imem_rdata;
      end else begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end else if (deliver && !if_valid) begin
      // Stalled but empty: nothing to protect, take the response directly.
      if_valid <= 1'b1;
      if_pc    <= req_pc;
      if_instr <= imem_rdata;
    end
  end

  // ---------------- skid buffer ----------------
  assign buf_load   = deliver && stall && if_valid;
  assign buf_unload = !br_taken && !stall && buf_valid;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .unload     (buf_unload),
    .clear      (br_taken),
    .load_pc    (req_pc),
    .load_instr (imem_rdata),
    .buf_valid  (buf_valid),
    .buf_pc     (buf_pc),
    .buf_instr  (buf_instr)
  );

endmodule
